// File: rtl/data_mem_param.sv
// Parametrised data memory: one synchronous write port, one registered read port,
// byte-lane write enables, write-first bypass, range checking and a post-reset clear.
module data_mem_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_range, rd_in_range;
    logic              wr_en, bypass;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] data_out_d;
    logic              rd_valid_d, addr_err_d, busy_d;

    // Range check collapses to a constant when the array fills the address space.
    if (DEPTH == 2**ADDR_W) begin : g_full_range
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_part_range
        assign wr_in_range = (wrAddr < LAST_IDX + ADDR_W'(1));
        assign rd_in_range = (rdAddr < LAST_IDX + ADDR_W'(1));
    end

    assign wr_en  = (state == READY) && write && wr_in_range && (|wr_be);
    assign bypass = wr_en && read && rd_in_range && (rdAddr == wrAddr);

    // Stored word with the enabled lanes replaced; feeds both the array and the bypass.
    always_comb begin
        wr_word = mem[wrAddr];
        for (int i = 0; i < int'(NB); i++) begin
            if (wr_be[i]) begin
                wr_word[8*i +: 8] = data_in[8*i +: 8];
            end
        end
    end

    // State register and clear pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_IDX) state_next = READY;
            READY:   state_next = READY;
            default: state_next = CLEAR;
        endcase
    end

    // Output next-values
    always_comb begin
        data_out_d = data_out;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;
        busy_d     = (state_next == CLEAR);
        if (state == READY) begin
            if (read) begin
                rd_valid_d = 1'b1;
                if (!rd_in_range) begin
                    data_out_d = '0;
                    addr_err_d = 1'b1;
                end else if (bypass) begin
                    data_out_d = wr_word;
                end else begin
                    data_out_d = mem[rdAddr];
                end
            end
            if (write && !wr_in_range) begin
                addr_err_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            busy     <= 1'b1;
        end else begin
            data_out <= data_out_d;
            rd_valid <= rd_valid_d;
            addr_err <= addr_err_d;
            busy     <= busy_d;
        end
    end

    // Storage array; no reset, contents are defined by the clear sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                mem[wrAddr] <= wr_word;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench for data_mem_param at DATA_W=16, ADDR_W=4, DEPTH=12.
module tb_data_mem_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        write;
    logic [1:0]  wr_be;
    logic [3:0]  wrAddr;
    logic [15:0] data_in;
    logic        read;
    logic [3:0]  rdAddr;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        busy;
    logic        addr_err;

    int total = 0;
    int bad   = 0;
    int cycles;
    int rv_seen;
    logic [15:0] model [12];

    data_mem_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(12)) dut (
        .clk(clk), .rst(rst), .write(write), .wr_be(wr_be), .wrAddr(wrAddr),
        .data_in(data_in), .read(read), .rdAddr(rdAddr), .data_out(data_out),
        .rd_valid(rd_valid), .busy(busy), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_clear(input string tag);
        cycles  = 0;
        rv_seen = 0;
        while (busy && cycles < 40) begin
            step();
            cycles++;
            if (rd_valid || addr_err) rv_seen++;
        end
        chk(tag, 32'(cycles), 32'd12);
        chk({tag, "_quiet"}, 32'(rv_seen), 32'd0);
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; wr_be = 2'b00; wrAddr = '0; data_in = '0;
        read = 1'b0; rdAddr = '0;
        for (int i = 0; i < 12; i++) model[i] = 16'h0000;

        step(); step();
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_busy",     32'(busy),     32'h1);

        // Clear sequence, with a request held to confirm it is ignored
        rst = 1'b0; read = 1'b1; rdAddr = 4'd2; write = 1'b1; wr_be = 2'b11;
        wrAddr = 4'd2; data_in = 16'hDEAD;
        wait_clear("clear_len");
        write = 1'b0; read = 1'b0; step();

        for (int i = 0; i < 12; i++) begin
            read = 1'b1; rdAddr = 4'(i);
            step();
            chk("clear_read_data", 32'(data_out), 32'h0);
            chk("clear_read_valid", 32'(rd_valid), 32'h1);
        end
        read = 1'b0;

        // Basic write then read
        write = 1'b1; wr_be = 2'b11; wrAddr = 4'd3; data_in = 16'hBEEF; model[3] = 16'hBEEF;
        step();
        chk("wr3_no_err", 32'(addr_err), 32'h0);
        write = 1'b0; read = 1'b1; rdAddr = 4'd3;
        step();
        chk("rd3_data", 32'(data_out), 32'hBEEF);
        chk("rd3_valid", 32'(rd_valid), 32'h1);
        read = 1'b0;
        step();
        chk("idle_valid", 32'(rd_valid), 32'h0);
        chk("idle_hold", 32'(data_out), 32'hBEEF);

        // Byte enables
        write = 1'b1; wr_be = 2'b11; wrAddr = 4'd5; data_in = 16'h1234; step();
        wr_be = 2'b01; data_in = 16'hABCD; step();
        write = 1'b0; read = 1'b1; rdAddr = 4'd5; step();
        chk("be_lo", 32'(data_out), 32'h12CD);
        read = 1'b0; write = 1'b1; wr_be = 2'b10; data_in = 16'h99FF; step();
        write = 1'b0; read = 1'b1; step();
        chk("be_hi", 32'(data_out), 32'h99CD);
        model[5] = 16'h99CD;
        read = 1'b0;

        // Write-first bypass
        write = 1'b1; wr_be = 2'b11; wrAddr = 4'd7; data_in = 16'h0F0F; step();
        wr_be = 2'b10; data_in = 16'hA5A5; read = 1'b1; rdAddr = 4'd7; step();
        chk("bypass_data", 32'(data_out), 32'hA50F);
        chk("bypass_valid", 32'(rd_valid), 32'h1);
        write = 1'b0; step();
        chk("bypass_reread", 32'(data_out), 32'hA50F);
        model[7] = 16'hA50F;
        read = 1'b0;

        // Out-of-range write
        write = 1'b1; wr_be = 2'b11; wrAddr = 4'd13; data_in = 16'h5555; step();
        chk("oor_wr_err", 32'(addr_err), 32'h1);
        write = 1'b0; step();
        chk("oor_wr_err_clr", 32'(addr_err), 32'h0);
        for (int i = 0; i < 12; i++) begin
            read = 1'b1; rdAddr = 4'(i);
            step();
            chk("oor_wr_mem", 32'(data_out), 32'(model[i]));
        end

        // Out-of-range read
        rdAddr = 4'd14; step();
        chk("oor_rd_data", 32'(data_out), 32'h0);
        chk("oor_rd_valid", 32'(rd_valid), 32'h1);
        chk("oor_rd_err", 32'(addr_err), 32'h1);
        read = 1'b0; step();
        chk("oor_rd_err_clr", 32'(addr_err), 32'h0);
        chk("oor_rd_valid_clr", 32'(rd_valid), 32'h0);

        // Both out of range together: one pulse
        write = 1'b1; wrAddr = 4'd15; read = 1'b1; rdAddr = 4'd12; step();
        chk("oor_both_err", 32'(addr_err), 32'h1);
        write = 1'b0; read = 1'b0; step();
        chk("oor_both_clr", 32'(addr_err), 32'h0);

        // Reset during a read stream
        read = 1'b1; rdAddr = 4'd3; step();
        chk("stream_a", 32'(data_out), 32'hBEEF);
        step();
        chk("stream_b", 32'(rd_valid), 32'h1);
        rst = 1'b1; step();
        chk("mid_rst_valid", 32'(rd_valid), 32'h0);
        chk("mid_rst_data", 32'(data_out), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        wait_clear("reclear_len");
        step();
        chk("reclear_rd3", 32'(data_out), 32'h0);
        chk("reclear_valid", 32'(rd_valid), 32'h1);
        read = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
